// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry and arbiter state type
package fb_pkg;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;
    localparam int FB_WORDS  = 76800;

    typedef enum logic {SERVE, CLEAR} state_t;
endpackage

// File: rtl/fb_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant, first requester at or above ptr wins
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] idx;

    // scan offsets downward so the closest requester above the pointer is the last (winning) hit
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares framebuffer port A among clients and runs the full-buffer clear engine
module fb_port_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = fb_pkg::FB_ADDR_W,
    parameter int DATA_W      = fb_pkg::FB_DATA_W,
    parameter int FB_WORDS    = fb_pkg::FB_WORDS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    input  logic [NUM_CLIENTS-1:0]        req_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    input  logic                          clear_start,
    input  logic [DATA_W-1:0]             clear_value,
    output logic                          clear_busy,
    output logic                          clear_done,
    output logic [7:0]                    oor_count,
    output logic [ADDR_W-1:0]             fb_addr,
    output logic [DATA_W-1:0]             fb_din,
    output logic                          fb_we,
    input  logic [DATA_W-1:0]             fb_dout
);
    import fb_pkg::*;

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    state_t                 state, state_nx;
    logic [1:0]             ptr;
    logic [NUM_CLIENTS-1:0] grant, rsp_pend;
    logic [IW-1:0]          gidx;
    logic [ADDR_W-1:0]      g_addr, clr_addr, hold_addr;
    logic [DATA_W-1:0]      g_wdata, clr_val, hold_din;
    logic                   g_write, g_oor, rsp_oor, hs, last;

    // requests are masked while a clear is starting or running
    rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
        .req   ((state == SERVE && !clear_start) ? req_valid : '0),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready  = grant;
    assign hs         = |grant;
    assign last       = clr_addr == ADDR_W'(FB_WORDS - 1);
    assign clear_busy = state == CLEAR;

    // select the granted client's request fields
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (grant[i]) gidx = IW'(i);
        g_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
        g_wdata = req_wdata[gidx*DATA_W +: DATA_W];
        g_write = req_write[gidx];
        g_oor   = g_addr >= ADDR_W'(FB_WORDS);
    end

    // state register; reset aborts a fill in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SERVE;
        else        state <= state_nx;
    end

    // clear starts only from SERVE and ends after the last visible word
    always_comb begin
        state_nx = (state == SERVE) ? (clear_start ? CLEAR : SERVE) : (last ? SERVE : CLEAR);
    end

    // port A drive: clear engine, granted request, or held idle values
    always_comb begin
        fb_we     = (state == CLEAR) || (hs && g_write && !g_oor);
        fb_addr   = (state == CLEAR) ? clr_addr : hs ? g_addr : hold_addr;
        fb_din    = (state == CLEAR) ? clr_val : hs ? g_wdata : hold_din;
        rsp_valid = rsp_pend;
        rsp_data  = rsp_oor ? '0 : fb_dout;
    end

    // pointer, clear counter, idle hold, read pipeline and out-of-range counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            clr_addr   <= '0;
            clr_val    <= '0;
            hold_addr  <= '0;
            hold_din   <= '0;
            rsp_pend   <= '0;
            rsp_oor    <= 1'b0;
            clear_done <= 1'b0;
            oor_count  <= '0;
        end else begin
            if (hs) ptr <= 2'((int'(gidx) + 1) % NUM_CLIENTS);
            if (state == SERVE && clear_start) clr_val <= clear_value;
            if (state == CLEAR) clr_addr <= last ? '0 : clr_addr + 1'b1;
            hold_addr  <= fb_addr;
            hold_din   <= fb_din;
            rsp_pend   <= grant & ~req_write;
            rsp_oor    <= g_oor;
            clear_done <= state == CLEAR && last;
            if (hs && g_oor && oor_count != 8'hFF) oor_count <= oor_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: randomized and directed checks of the framebuffer port arbiter against a reference model
module tb_fb_port_arbiter;
    localparam int N  = 2;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int W  = 76800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]  req_ready, rsp_valid;
    logic [DW-1:0] rsp_data, fb_din, fb_dout;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_value = '0;
    logic          clear_busy, clear_done, fb_we;
    logic [7:0]    oor_count;
    logic [AW-1:0] fb_addr;

    logic [DW-1:0] mem [W];

    int compared = 0;
    int mismatched = 0;

    int            rr_ptr = 0;
    int            exp_oor = 0;
    logic [DW-1:0] ref_mem [W];
    bit            ref_known [W];
    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_last_din = '0;

    always #5 clk = ~clk;

    fb_port_arbiter #(.NUM_CLIENTS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .clear_start (clear_start),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .oor_count   (oor_count),
        .fb_addr     (fb_addr),
        .fb_din      (fb_din),
        .fb_we       (fb_we),
        .fb_dout     (fb_dout)
    );

    // framebuffer port A: synchronous write, 1-cycle read, poison value outside the buffer
    always @(posedge clk) begin
        if (fb_we && fb_addr < AW'(W)) mem[fb_addr] <= fb_din;
        fb_dout <= (fb_addr < AW'(W)) ? mem[fb_addr] : 16'hDEAD;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid   = '0;
        req_write   = '0;
        clear_start = 1'b0;
    endtask

    task automatic set_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[c]          = 1'b1;
        req_write[c]          = w;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = d;
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (rr_ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_accept(input int g);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = req_addr[g*AW +: AW];
        d = req_wdata[g*DW +: DW];
        rr_ptr = (g + 1) % N;
        if (a >= AW'(W)) begin
            if (exp_oor < 255) exp_oor++;
        end else if (req_write[g]) begin
            ref_mem[a]   = d;
            ref_known[a] = 1'b1;
        end
        m_last_addr = a;
        m_last_din  = d;
    endtask

    task automatic model_clear(input logic [DW-1:0] v);
        for (int i = 0; i < W; i++) begin
            ref_mem[i]   = v;
            ref_known[i] = 1'b1;
        end
        m_last_addr = AW'(W - 1);
        m_last_din  = v;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0 || oor_count !== 8'd0 || fb_we !== 1'b0 || rsp_valid !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: busy=%b done=%b oor=%0d we=%b rsp=%b, want all zero", clear_busy, clear_done, oor_count, fb_we, rsp_valid);
        end
        compared++;
        if (fb_addr !== '0 || req_ready !== '0) begin
            mismatched++;
            $display("FAIL reset_port: fb_addr=%h ready=%b, want 0 0", fb_addr, req_ready);
        end
        step();
        rst_n = 1'b1;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        @(negedge clk);
        compared++;
        if (req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL reset_pointer: ready=%b, want 01", req_ready);
        end
        model_accept(model_grant(req_valid));
        step();
        idle();
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, AW'(16), 16'hBEEF);
        @(negedge clk);
        compared++;
        if (req_ready !== 2'b01 || fb_we !== 1'b1 || fb_addr !== AW'(16) || fb_din !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL single_write: ready=%b we=%b addr=%h din=%h, want 01 1 00010 beef", req_ready, fb_we, fb_addr, fb_din);
        end
        model_accept(0);
        step();
        idle();
        set_req(0, 1'b0, AW'(16), 16'h0000);
        @(negedge clk);
        compared++;
        if (req_ready !== 2'b01 || fb_we !== 1'b0 || fb_addr !== AW'(16)) begin
            mismatched++;
            $display("FAIL single_read: ready=%b we=%b addr=%h, want 01 0 00010", req_ready, fb_we, fb_addr);
        end
        model_accept(0);
        step();
        idle();
        @(negedge clk);
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL read_back: rsp=%b data=%h, want 01 beef", rsp_valid, rsp_data);
        end
        step();
        @(negedge clk);
        compared++;
        if (rsp_valid !== '0 || fb_we !== 1'b0 || fb_addr !== AW'(16) || fb_din !== 16'h0000) begin
            mismatched++;
            $display("FAIL idle_hold: rsp=%b we=%b addr=%h din=%h, want 00 0 00010 0000", rsp_valid, fb_we, fb_addr, fb_din);
        end
        step();
    endtask

    task automatic test_fairness();
        int cnt [N];
        logic [N-1:0] prev, e;
        int g;
        cnt  = '{default: 0};
        prev = '0;
        for (int c = 0; c <= 6; c++) begin
            idle();
            if (c < 6) begin
                set_req(0, 1'b0, AW'(16), '0);
                set_req(1, 1'b0, AW'(16), '0);
            end
            @(negedge clk);
            if (c > 0) begin
                compared++;
                if (rsp_valid !== prev) begin
                    mismatched++;
                    $display("FAIL fair_rsp[%0d]: rsp=%b, want %b", c, rsp_valid, prev);
                end
            end
            g = model_grant(req_valid);
            e = '0;
            if (g >= 0) e[g] = 1'b1;
            compared++;
            if (req_ready !== e) begin
                mismatched++;
                $display("FAIL fair_grant[%0d]: ready=%b, want %b", c, req_ready, e);
            end
            for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
            if (g >= 0) model_accept(g);
            prev = e;
            step();
        end
        compared++;
        if (cnt[0] != 3 || cnt[1] != 3) begin
            mismatched++;
            $display("FAIL fair_count: accepts=%0d/%0d, want 3/3", cnt[0], cnt[1]);
        end
    endtask

    task automatic test_pipelined();
        for (int i = 0; i < 3; i++) begin
            idle();
            set_req(1, 1'b1, AW'(5 + i), DW'(5 + i));
            @(negedge clk);
            compared++;
            if (req_ready !== 2'b10 || fb_we !== 1'b1 || fb_addr !== AW'(5 + i)) begin
                mismatched++;
                $display("FAIL preload[%0d]: ready=%b we=%b addr=%h", i, req_ready, fb_we, fb_addr);
            end
            model_accept(1);
            step();
        end
        for (int c = 0; c <= 3; c++) begin
            idle();
            if (c < 3) set_req(1, 1'b0, AW'(5 + c), '0);
            @(negedge clk);
            if (c > 0) begin
                compared++;
                if (rsp_valid !== 2'b10 || rsp_data !== DW'(4 + c)) begin
                    mismatched++;
                    $display("FAIL pipe_rsp[%0d]: rsp=%b data=%h, want 10 %h", c, rsp_valid, rsp_data, DW'(4 + c));
                end
            end
            if (c < 3) model_accept(1);
            step();
        end
    endtask

    task automatic test_out_of_range();
        idle();
        set_req(0, 1'b1, AW'(W), 16'h1234);
        @(negedge clk);
        compared++;
        if (req_ready !== 2'b01 || fb_we !== 1'b0) begin
            mismatched++;
            $display("FAIL oor_write: ready=%b we=%b, want 01 0", req_ready, fb_we);
        end
        model_accept(0);
        step();
        idle();
        set_req(0, 1'b0, AW'(100000), '0);
        @(negedge clk);
        compared++;
        if (req_ready !== 2'b01 || fb_we !== 1'b0) begin
            mismatched++;
            $display("FAIL oor_read: ready=%b we=%b, want 01 0", req_ready, fb_we);
        end
        model_accept(0);
        step();
        idle();
        @(negedge clk);
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL oor_rsp: rsp=%b data=%h, want 01 0000", rsp_valid, rsp_data);
        end
        compared++;
        if (oor_count !== 8'd2 || exp_oor != 2) begin
            mismatched++;
            $display("FAIL oor_count: got %0d, want 2", oor_count);
        end
        step();
    endtask

    task automatic test_random(input int n, input int oor_pct);
        bit            pend;
        logic [N-1:0]  e_rv, e;
        logic [DW-1:0] e_rd;
        bit            e_known;
        int            g;
        logic [AW-1:0] a;
        pend = 1'b0;
        e_rv = '0;
        e_rd = '0;
        e_known = 1'b0;
        for (int c = 0; c <= n; c++) begin
            idle();
            if (c < n) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 99) < 70) begin
                        a = ($urandom_range(0, 99) < oor_pct) ? AW'($urandom_range(W, (1 << AW) - 1)) : AW'($urandom_range(0, 63));
                        set_req(i, 1'($urandom_range(0, 1)), a, DW'($urandom));
                    end
                end
            end
            @(negedge clk);
            if (pend) begin
                compared++;
                if (rsp_valid !== e_rv) begin
                    mismatched++;
                    $display("FAIL rand_rsp_valid[%0d]: got %b, want %b", c, rsp_valid, e_rv);
                end
                if (e_rv != '0 && e_known) begin
                    compared++;
                    if (rsp_data !== e_rd) begin
                        mismatched++;
                        $display("FAIL rand_rsp_data[%0d]: got %h, want %h", c, rsp_data, e_rd);
                    end
                end
            end
            compared++;
            if (oor_count !== 8'(exp_oor)) begin
                mismatched++;
                $display("FAIL rand_oor_count[%0d]: got %0d, want %0d", c, oor_count, exp_oor);
            end
            g = model_grant(req_valid);
            e = '0;
            if (g >= 0) e[g] = 1'b1;
            compared++;
            if (req_ready !== e) begin
                mismatched++;
                $display("FAIL rand_grant[%0d]: ready=%b, want %b", c, req_ready, e);
            end
            if (g >= 0) begin
                a = req_addr[g*AW +: AW];
                compared++;
                if (fb_we !== (req_write[g] && a < AW'(W)) || fb_addr !== a || (req_write[g] && fb_din !== req_wdata[g*DW +: DW])) begin
                    mismatched++;
                    $display("FAIL rand_port[%0d]: we=%b addr=%h din=%h, want write=%b addr=%h din=%h", c, fb_we, fb_addr, fb_din, req_write[g], a, req_wdata[g*DW +: DW]);
                end
                e_rv    = req_write[g] ? '0 : e;
                e_known = (a >= AW'(W)) || ref_known[a];
                e_rd    = (a >= AW'(W)) ? '0 : ref_mem[a];
                model_accept(g);
            end else begin
                compared++;
                if (fb_we !== 1'b0 || fb_addr !== m_last_addr || fb_din !== m_last_din) begin
                    mismatched++;
                    $display("FAIL rand_idle[%0d]: we=%b addr=%h din=%h, want 0 %h %h", c, fb_we, fb_addr, fb_din, m_last_addr, m_last_din);
                end
                e_rv = '0;
            end
            pend = 1'b1;
            step();
        end
    endtask

    task automatic test_saturate();
        test_random(600, 90);
        @(negedge clk);
        compared++;
        if (oor_count !== 8'd255) begin
            mismatched++;
            $display("FAIL oor_saturate: got %0d, want 255", oor_count);
        end
        step();
    endtask

    task automatic test_clear();
        int lowcnt, busy, done, bad;
        bit ended;
        int sa [3];
        logic [DW-1:0] ed;
        sa = '{0, 38400, W - 1};
        idle();
        set_req(0, 1'b0, AW'(16), '0);
        ed = ref_mem[16];
        @(negedge clk);
        model_accept(0);
        step();
        idle();
        set_req(0, 1'b0, AW'(32), '0);
        clear_start = 1'b1;
        clear_value = 16'h001F;
        @(negedge clk);
        compared++;
        if (req_ready !== '0 || fb_we !== 1'b0 || clear_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_start_cycle: ready=%b we=%b busy=%b, want 00 0 0", req_ready, fb_we, clear_busy);
        end
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== ed) begin
            mismatched++;
            $display("FAIL read_before_clear: rsp=%b data=%h, want 01 %h", rsp_valid, rsp_data, ed);
        end
        lowcnt = 1;
        busy = 0;
        done = 0;
        bad = 0;
        ended = 1'b0;
        for (int k = 0; k < 80000 && !ended; k++) begin
            step();
            clear_start = (k == 500);
            clear_value = (k == 500) ? 16'h7777 : 16'h001F;
            @(negedge clk);
            if (clear_busy === 1'b1) begin
                if (fb_we !== 1'b1 || fb_addr !== AW'(busy) || fb_din !== 16'h001F) bad++;
                busy++;
            end
            if (clear_done === 1'b1) done++;
            if (req_ready === '0) lowcnt++;
            else ended = 1'b1;
        end
        compared++;
        if (!ended || req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL clear_end: ready=%b ended=%b, want 01 1", req_ready, ended);
        end
        compared++;
        if (lowcnt != 76801) begin
            mismatched++;
            $display("FAIL clear_ready_low: got %0d cycles, want 76801", lowcnt);
        end
        compared++;
        if (busy != 76800) begin
            mismatched++;
            $display("FAIL clear_busy_len: got %0d cycles, want 76800", busy);
        end
        compared++;
        if (done != 1) begin
            mismatched++;
            $display("FAIL clear_done_pulses: got %0d, want 1", done);
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL clear_writes: %0d bad cycles, want 0", bad);
        end
        model_clear(16'h001F);
        if (ended) model_accept(0);
        clear_start = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            step();
            idle();
            if (c < 3) set_req(1, 1'b0, AW'(sa[c]), '0);
            @(negedge clk);
            compared++;
            if (rsp_valid !== ((c == 0) ? 2'b01 : 2'b10) || rsp_data !== 16'h001F || clear_done !== 1'b0) begin
                mismatched++;
                $display("FAIL clear_spot[%0d]: rsp=%b data=%h done=%b, want data 001f done 0", c, rsp_valid, rsp_data, clear_done);
            end
            if (c < 3) model_accept(1);
        end
        step();
    endtask

    task automatic test_reset_mid_clear();
        int bad;
        idle();
        clear_start = 1'b1;
        clear_value = 16'h0AAA;
        @(negedge clk);
        for (int k = 0; k <= 1000; k++) begin
            step();
            clear_start = 1'b0;
            @(negedge clk);
        end
        compared++;
        if (fb_addr !== AW'(1000) || clear_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_clear_pos: addr=%h busy=%b, want 003e8 1", fb_addr, clear_busy);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (clear_busy !== 1'b0 || fb_we !== 1'b0) begin
            mismatched++;
            $display("FAIL async_abort: busy=%b we=%b, want 0 0", clear_busy, fb_we);
        end
        for (int i = 0; i < 1000; i++) ref_mem[i] = 16'h0AAA;
        rr_ptr = 0;
        exp_oor = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clear_done !== 1'b0 || clear_busy !== 1'b0) bad++;
            step();
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL abort_no_done: %0d cycles with done/busy, want 0", bad);
        end
        compared++;
        if (oor_count !== 8'd0) begin
            mismatched++;
            $display("FAIL abort_oor_reset: got %0d, want 0", oor_count);
        end
        for (int c = 0; c <= 2; c++) begin
            idle();
            if (c < 2) set_req(0, 1'b0, AW'((c == 0) ? 999 : 1000), '0);
            @(negedge clk);
            if (c > 0) begin
                compared++;
                if (rsp_valid !== 2'b01 || rsp_data !== ((c == 1) ? 16'h0AAA : 16'h001F)) begin
                    mismatched++;
                    $display("FAIL abort_word[%0d]: rsp=%b data=%h, want 01 %h", c, rsp_valid, rsp_data, (c == 1) ? 16'h0AAA : 16'h001F);
                end
            end
            if (c < 2) model_accept(0);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fairness();
        test_pipelined();
        test_out_of_range();
        test_random(300, 10);
        test_saturate();
        test_clear();
        test_random(200, 5);
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
